// File: rtl/mem_port_arbiter.sv
// Shares one single-port sync-read memory between fetch (I) and data (D) requesters.
// Grant is same-cycle combinational, read data returns one cycle later; D has priority with I anti-starvation.
module mem_port_arbiter #(
  parameter int DBITS      = 16,
  parameter int ABITS      = 12,
  parameter int STARVE_MAX = 3
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             I_REQ,
  input  logic [DBITS-1:0] I_ADDR,
  output logic             I_GNT,
  output logic             I_STALL,
  output logic             I_RVALID,
  output logic [DBITS-1:0] I_RDATA,
  input  logic             D_REQ,
  input  logic             D_WE,
  input  logic [DBITS-1:0] D_ADDR,
  input  logic [DBITS-1:0] D_DIN,
  output logic             D_GNT,
  output logic             D_STALL,
  output logic             D_RVALID,
  output logic [DBITS-1:0] D_RDATA,
  output logic [ABITS-1:0] M_ADDR,
  output logic [DBITS-1:0] M_DIN,
  output logic             M_WE,
  input  logic [DBITS-1:0] M_DOUT,
  output logic [15:0]      CONFLICT_CNT
);

  localparam logic [1:0]       SEL_NONE = 2'd0;
  localparam logic [1:0]       SEL_I    = 2'd1;
  localparam logic [1:0]       SEL_D    = 2'd2;
  localparam logic [DBITS-1:0] OOR_DATA = DBITS'(16'hDEAD);

  function automatic logic inrange(input logic [DBITS-1:0] a);
    return a[DBITS-1:ABITS+1] == '0;
  endfunction

  logic [3:0]       starve_q, starve_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [1:0]       rsel_q, rsel_d;
  logic             roor_q, roor_d;
  logic [ABITS-1:0] maddr_q, maddr_d;
  logic             i_gnt, d_gnt, force_i;
  logic [DBITS-1:0] gnt_addr;
  logic             unused_addr_lsb;

  assign force_i = (starve_q == 4'(STARVE_MAX));

  // Grants are gated by RSTN so nothing reaches the array while in reset.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (RSTN) begin
      if (D_REQ && !(I_REQ && force_i)) d_gnt = 1'b1;
      else if (I_REQ)                   i_gnt = 1'b1;
    end
  end

  assign gnt_addr        = d_gnt ? D_ADDR : I_ADDR;
  assign unused_addr_lsb = gnt_addr[0];

  always_comb begin
    maddr_d  = (i_gnt || d_gnt) ? gnt_addr[ABITS:1] : maddr_q;
    starve_d = starve_q;
    if (i_gnt || !I_REQ)                                    starve_d = 4'd0;
    else if (d_gnt && (starve_q < 4'(STARVE_MAX)))          starve_d = starve_q + 4'd1;
    cnt_d = cnt_q;
    if (I_REQ && D_REQ && (cnt_q != 16'hFFFF))              cnt_d = cnt_q + 16'd1;
    rsel_d = SEL_NONE;
    if (i_gnt)                                              rsel_d = SEL_I;
    else if (d_gnt && !D_WE)                                rsel_d = SEL_D;
    roor_d = !inrange(gnt_addr);
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      starve_q <= 4'd0;
      cnt_q    <= 16'd0;
      rsel_q   <= SEL_NONE;
      roor_q   <= 1'b0;
      maddr_q  <= '0;
    end else begin
      starve_q <= starve_d;
      cnt_q    <= cnt_d;
      rsel_q   <= rsel_d;
      roor_q   <= roor_d;
      maddr_q  <= maddr_d;
    end
  end

  assign I_GNT        = i_gnt;
  assign D_GNT        = d_gnt;
  assign I_STALL      = I_REQ & ~i_gnt;
  assign D_STALL      = D_REQ & ~d_gnt;
  assign M_ADDR       = maddr_d;
  assign M_DIN        = D_DIN;
  assign M_WE         = d_gnt & D_WE & inrange(D_ADDR);
  assign I_RVALID     = (rsel_q == SEL_I);
  assign D_RVALID     = (rsel_q == SEL_D);
  assign I_RDATA      = roor_q ? OOR_DATA : M_DOUT;
  assign D_RDATA      = roor_q ? OOR_DATA : M_DOUT;
  assign CONFLICT_CNT = cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboarded bench for mem_port_arbiter with a behavioural sync-read memory.
module tb_mem_port_arbiter;

  logic        CLK, RSTN;
  logic        I_REQ, I_GNT, I_STALL, I_RVALID;
  logic [15:0] I_ADDR, I_RDATA;
  logic        D_REQ, D_WE, D_GNT, D_STALL, D_RVALID;
  logic [15:0] D_ADDR, D_DIN, D_RDATA;
  logic [11:0] M_ADDR;
  logic [15:0] M_DIN, M_DOUT;
  logic        M_WE;
  logic [15:0] CONFLICT_CNT;

  mem_port_arbiter #(.DBITS(16), .ABITS(12), .STARVE_MAX(3)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_GNT(I_GNT), .I_STALL(I_STALL),
    .I_RVALID(I_RVALID), .I_RDATA(I_RDATA),
    .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_DIN(D_DIN),
    .D_GNT(D_GNT), .D_STALL(D_STALL), .D_RVALID(D_RVALID), .D_RDATA(D_RDATA),
    .M_ADDR(M_ADDR), .M_DIN(M_DIN), .M_WE(M_WE), .M_DOUT(M_DOUT),
    .CONFLICT_CNT(CONFLICT_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory model with a backdoor load port for preloading.
  logic [15:0] mem [0:4095];
  logic        bd_we;
  logic [11:0] bd_addr;
  logic [15:0] bd_dat;
  always @(posedge CLK) begin
    if (bd_we)     mem[bd_addr] <= bd_dat;
    else if (M_WE) mem[M_ADDR]  <= M_DIN;
    M_DOUT <= mem[M_ADDR];
  end

  typedef struct {
    logic        is_d;
    logic [15:0] dat;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push(input logic is_d, input logic [15:0] dat);
    exp_t x;
    x.is_d = is_d;
    x.dat  = dat;
    exp_q.push_back(x);
  endtask

  task automatic samp();
    @(negedge CLK);
  endtask

  task automatic adv();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: every read return is matched against the oldest expectation.
  always @(negedge CLK) begin
    if (RSTN && (I_RVALID || D_RVALID)) begin
      checks++;
      if (I_RVALID && D_RVALID) begin
        errors++;
        $display("FAIL rvalid_both: I_RVALID=1 D_RVALID=1 expected one at %0t", $time);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rvalid_unexpected: I=%0b D=%0b with no pending read at %0t",
                 I_RVALID, D_RVALID, $time);
      end else begin
        e = exp_q.pop_front();
        if ((e.is_d !== D_RVALID) || (e.dat !== (D_RVALID ? D_RDATA : I_RDATA))) begin
          errors++;
          $display("FAIL rdata: got D=%0b data %h expected D=%0b data %h at %0t",
                   D_RVALID, D_RVALID ? D_RDATA : I_RDATA, e.is_d, e.dat, $time);
        end
      end
    end
  end

  int iseq [10] = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0};

  initial begin
    RSTN = 1'b0; bd_we = 1'b0; bd_addr = '0; bd_dat = '0;
    I_REQ = 1'b1; I_ADDR = 16'h0200;
    D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 16'h0010; D_DIN = 16'h7777;

    // Reset with requests asserted: no grants, no write.
    adv();
    bd_we = 1'b1; bd_addr = 12'h100; bd_dat = 16'h1234;
    samp();
    chk("rst_i_gnt", I_GNT, 0);
    chk("rst_d_gnt", D_GNT, 0);
    chk("rst_m_we", M_WE, 0);
    chk("rst_rvalid", {I_RVALID, D_RVALID}, 0);
    adv();
    bd_addr = 12'hFFC; bd_dat = 16'h5A5A;
    samp();
    chk("rst_conflict", CONFLICT_CNT, 0);
    adv();
    bd_we = 1'b0; I_REQ = 1'b0; D_REQ = 1'b0; D_WE = 1'b0;
    RSTN = 1'b1;
    adv();

    // Single I fetch.
    I_REQ = 1'b1; I_ADDR = 16'h0200;
    samp();
    chk("i_gnt", I_GNT, 1);
    chk("i_d_gnt", D_GNT, 0);
    chk("i_m_addr", M_ADDR, 12'h100);
    chk("i_stall", I_STALL, 0);
    push(1'b0, 16'h1234);
    adv();
    I_REQ = 1'b0;
    adv();

    // D write then D read of same address.
    D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 16'h0010; D_DIN = 16'hBEEF;
    samp();
    chk("dw_gnt", D_GNT, 1);
    chk("dw_m_we", M_WE, 1);
    chk("dw_m_addr", M_ADDR, 12'h008);
    chk("dw_m_din", M_DIN, 16'hBEEF);
    adv();
    D_WE = 1'b0;
    samp();
    chk("dr_gnt", D_GNT, 1);
    chk("dr_m_we", M_WE, 0);
    push(1'b1, 16'hBEEF);
    adv();
    D_REQ = 1'b0;
    adv();

    // Sustained conflict: D,D,D,I repeating.
    I_REQ = 1'b1; I_ADDR = 16'h0200; D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 16'h0010;
    for (int k = 0; k < 10; k++) begin
      samp();
      chk($sformatf("cf_i_gnt%0d", k), I_GNT, iseq[k]);
      chk($sformatf("cf_d_gnt%0d", k), D_GNT, iseq[k] == 0);
      chk($sformatf("cf_i_stall%0d", k), I_STALL, iseq[k] == 0);
      if (iseq[k] == 1) push(1'b0, 16'h1234);
      else              push(1'b1, 16'hBEEF);
      adv();
    end
    I_REQ = 1'b0; D_REQ = 1'b0;
    samp();
    chk("cf_count", CONFLICT_CNT, 10);
    adv();

    // Out-of-range write and read, then confirm the aliased word is untouched.
    D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 16'hFFF8; D_DIN = 16'h1111;
    samp();
    chk("oor_w_gnt", D_GNT, 1);
    chk("oor_w_m_we", M_WE, 0);
    adv();
    D_WE = 1'b0; D_ADDR = 16'hFFF2;
    samp();
    chk("oor_r_gnt", D_GNT, 1);
    chk("oor_r_stall", D_STALL, 0);
    push(1'b1, 16'hDEAD);
    adv();
    D_ADDR = 16'h1FF8;
    samp();
    push(1'b1, 16'h5A5A);
    adv();
    D_REQ = 1'b0;
    adv();

    // Reset arriving while an I read is in flight.
    I_REQ = 1'b1; I_ADDR = 16'h0200;
    samp();
    chk("mr_i_gnt", I_GNT, 1);
    adv();
    I_REQ = 1'b0;
    RSTN = 1'b0;
    #1;
    chk("mr_i_rvalid", I_RVALID, 0);
    chk("mr_conflict", CONFLICT_CNT, 0);
    adv();
    RSTN = 1'b1;
    for (int k = 0; k < 3; k++) begin
      samp();
      chk($sformatf("mr_quiet%0d", k), {I_RVALID, D_RVALID}, 0);
      adv();
    end

    // Saturation: D writes out of range (no returns), I reads out of range every 4th cycle.
    I_REQ = 1'b1; I_ADDR = 16'hE000; D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 16'hFFF8;
    for (int k = 0; k < 70000; k++) begin
      samp();
      if ((k % 4) == 3) push(1'b0, 16'hDEAD);
      if (k == 65534) chk("sat_fffe", CONFLICT_CNT, 16'hFFFE);
      if (k == 65535) chk("sat_ffff", CONFLICT_CNT, 16'hFFFF);
      adv();
    end
    I_REQ = 1'b0; D_REQ = 1'b0;
    samp();
    chk("sat_final", CONFLICT_CNT, 16'hFFFF);
    adv();
    adv();
    samp();
    chk("pending_reads", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
